// File: rtl/sparc_br_pkg.sv
// sparc_br_pkg: shared encodings for the SPARC V8 PC/nPC sequencer.
// Instruction field codes, condition codes, fcc codes and sequencer state.
package sparc_br_pkg;

  localparam logic [1:0] OP_BRANCH = 2'b00;
  localparam logic [1:0] OP_CALL   = 2'b01;
  localparam logic [1:0] OP_ARITH  = 2'b10;
  localparam logic [1:0] OP_MEM    = 2'b11;

  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [2:0] OP2_SETHI = 3'b100;
  localparam logic [2:0] OP2_FBFCC = 3'b110;

  // Bicc names; FBfcc reuses the same 4-bit codes
  // (N,NE,LG,UL,L,UG,G,U,A,E,UE,GE,UGE,LE,ULE,O).
  localparam logic [3:0] COND_N   = 4'b0000;
  localparam logic [3:0] COND_E   = 4'b0001;
  localparam logic [3:0] COND_LE  = 4'b0010;
  localparam logic [3:0] COND_L   = 4'b0011;
  localparam logic [3:0] COND_LEU = 4'b0100;
  localparam logic [3:0] COND_CS  = 4'b0101;
  localparam logic [3:0] COND_NEG = 4'b0110;
  localparam logic [3:0] COND_VS  = 4'b0111;
  localparam logic [3:0] COND_A   = 4'b1000;
  localparam logic [3:0] COND_NE  = 4'b1001;
  localparam logic [3:0] COND_G   = 4'b1010;
  localparam logic [3:0] COND_GE  = 4'b1011;
  localparam logic [3:0] COND_GU  = 4'b1100;
  localparam logic [3:0] COND_CC  = 4'b1101;
  localparam logic [3:0] COND_POS = 4'b1110;
  localparam logic [3:0] COND_VC  = 4'b1111;

  localparam logic [1:0] FCC_E = 2'd0;
  localparam logic [1:0] FCC_L = 2'd1;
  localparam logic [1:0] FCC_G = 2'd2;
  localparam logic [1:0] FCC_U = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DSLOT,
    ST_ANNUL
  } seq_state_t;

endpackage

// File: rtl/sparc_cond_eval.sv
// sparc_cond_eval: evaluates a Bicc cond against icc or an FBfcc cond against fcc.
// Ports: i_cond, i_icc {N,Z,V,C}, i_fcc, i_use_fcc (select fcc table), o_true.
module sparc_cond_eval
  import sparc_br_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_icc,
  input  logic [1:0] i_fcc,
  input  logic       i_use_fcc,
  output logic       o_true
);

  logic w_n, w_z, w_v, w_c;
  logic w_e, w_l, w_g, w_u;
  logic w_icc_true;
  logic w_fcc_true;

  assign {w_n, w_z, w_v, w_c} = i_icc;

  assign w_e = (i_fcc == FCC_E);
  assign w_l = (i_fcc == FCC_L);
  assign w_g = (i_fcc == FCC_G);
  assign w_u = (i_fcc == FCC_U);

  always_comb begin
    w_icc_true = 1'b0;
    unique case (i_cond)
      COND_N:   w_icc_true = 1'b0;
      COND_E:   w_icc_true = w_z;
      COND_LE:  w_icc_true = w_z | (w_n ^ w_v);
      COND_L:   w_icc_true = w_n ^ w_v;
      COND_LEU: w_icc_true = w_c | w_z;
      COND_CS:  w_icc_true = w_c;
      COND_NEG: w_icc_true = w_n;
      COND_VS:  w_icc_true = w_v;
      COND_A:   w_icc_true = 1'b1;
      COND_NE:  w_icc_true = ~w_z;
      COND_G:   w_icc_true = ~(w_z | (w_n ^ w_v));
      COND_GE:  w_icc_true = ~(w_n ^ w_v);
      COND_GU:  w_icc_true = ~(w_c | w_z);
      COND_CC:  w_icc_true = ~w_c;
      COND_POS: w_icc_true = ~w_n;
      COND_VC:  w_icc_true = ~w_v;
    endcase
  end

  always_comb begin
    w_fcc_true = 1'b0;
    unique case (i_cond)
      4'b0000: w_fcc_true = 1'b0;
      4'b0001: w_fcc_true = w_l | w_g | w_u;
      4'b0010: w_fcc_true = w_l | w_g;
      4'b0011: w_fcc_true = w_u | w_l;
      4'b0100: w_fcc_true = w_l;
      4'b0101: w_fcc_true = w_u | w_g;
      4'b0110: w_fcc_true = w_g;
      4'b0111: w_fcc_true = w_u;
      4'b1000: w_fcc_true = 1'b1;
      4'b1001: w_fcc_true = w_e;
      4'b1010: w_fcc_true = w_u | w_e;
      4'b1011: w_fcc_true = w_g | w_e;
      4'b1100: w_fcc_true = w_u | w_g | w_e;
      4'b1101: w_fcc_true = w_l | w_e;
      4'b1110: w_fcc_true = w_u | w_l | w_e;
      4'b1111: w_fcc_true = w_e | w_l | w_g;
    endcase
  end

  assign o_true = i_use_fcc ? w_fcc_true : w_icc_true;

endmodule

// File: rtl/sparc_branch_sequencer.sv
// sparc_branch_sequencer: SPARC V8 PC/nPC sequencer with delayed branch and annul.
// Ports: Clk, RESET, advance, ir, icc, fcc, trap_req, trap_vec -> pc, npc, annul_cur, cond_true, is_ba, is_bn, taken_cnt, annul_cnt.
module sparc_branch_sequencer
  import sparc_br_pkg::*;
#(
  parameter int                   ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          FCC_EN   = 1,
  parameter int                   CNT_W    = 16
)(
  input  logic              Clk,
  input  logic              RESET,
  input  logic              advance,
  input  logic [31:0]       ir,
  input  logic [3:0]        icc,
  input  logic [1:0]        fcc,
  input  logic              trap_req,
  input  logic [ADDR_W-1:0] trap_vec,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  output logic              annul_cur,
  output logic              cond_true,
  output logic              is_ba,
  output logic              is_bn,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  annul_cnt
);

  seq_state_t        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_npc;
  logic [CNT_W-1:0]  r_taken_cnt;
  logic [CNT_W-1:0]  r_annul_cnt;

  logic [1:0]        w_op;
  logic              w_a;
  logic [3:0]        w_cond;
  logic [2:0]        w_op2;
  logic              w_is_bicc;
  logic              w_is_fbfcc;
  logic              w_is_call;
  logic              w_is_br;
  logic              w_cond_true;
  logic              w_taken;
  logic              w_annul_nxt;
  logic signed [31:0] w_disp;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_seq;

  assign w_op   = ir[31:30];
  assign w_a    = ir[29];
  assign w_cond = ir[28:25];
  assign w_op2  = ir[24:22];

  assign w_is_bicc  = (w_op == OP_BRANCH) && (w_op2 == OP2_BICC);
  assign w_is_fbfcc = (FCC_EN != 0) && (w_op == OP_BRANCH)
                      && (w_op2 == OP2_FBFCC);
  assign w_is_call  = (w_op == OP_CALL);
  assign w_is_br    = w_is_bicc | w_is_fbfcc;

  sparc_cond_eval u_cond (
    .i_cond    (w_cond),
    .i_icc     (icc),
    .i_fcc     (fcc),
    .i_use_fcc (w_is_fbfcc),
    .o_true    (w_cond_true)
  );

  assign cond_true = w_cond_true;
  assign is_ba     = w_is_br && (w_cond == COND_A);
  assign is_bn     = w_is_br && (w_cond == COND_N);

  // Byte displacement: disp30<<2 for CALL, sext(disp22)<<2 for branches.
  // The signed cast sign-extends when ADDR_W exceeds 32.
  assign w_disp   = w_is_call ? {ir[29:0], 2'b00}
                              : {{8{ir[21]}}, ir[21:0], 2'b00};
  assign w_target = r_pc + ADDR_W'(w_disp);
  assign w_seq    = r_npc + ADDR_W'(4);

  assign w_taken     = w_is_call | (w_is_br & w_cond_true);
  // BN,a and untaken conditionals annul their slot; BA,a annuls too.
  assign w_annul_nxt = w_is_br & w_a & (~w_taken | is_ba);

  always_ff @(posedge Clk) begin
    if (RESET) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_npc       <= RESET_PC + ADDR_W'(4);
      r_taken_cnt <= '0;
      r_annul_cnt <= '0;
    end else if (trap_req) begin
      r_state <= ST_RUN;
      r_pc    <= trap_vec;
      r_npc   <= trap_vec + ADDR_W'(4);
    end else if (advance) begin
      r_pc <= r_npc;
      if (r_state == ST_ANNUL) begin
        // Annulled instruction is skipped, never decoded as a CTI.
        r_npc   <= w_seq;
        r_state <= ST_RUN;
        if (r_annul_cnt != '1)
          r_annul_cnt <= r_annul_cnt + CNT_W'(1);
      end else begin
        r_npc <= w_taken ? w_target : w_seq;
        if (w_taken && (r_taken_cnt != '1))
          r_taken_cnt <= r_taken_cnt + CNT_W'(1);
        if (w_annul_nxt)
          r_state <= ST_ANNUL;
        else if (w_taken)
          r_state <= ST_DSLOT;
        else
          r_state <= ST_RUN;
      end
    end
  end

  assign pc        = r_pc;
  assign npc       = r_npc;
  assign annul_cur = (r_state == ST_ANNUL);
  assign taken_cnt = r_taken_cnt;
  assign annul_cnt = r_annul_cnt;

endmodule

// File: tb/tb_sparc_branch_sequencer.sv
// tb_sparc_branch_sequencer: directed table-driven bench for the sequencer.
// Drives three instances: defaults, FCC_EN=0, CNT_W=2.
module tb_sparc_branch_sequencer;

  logic        Clk;
  logic        RESET;
  logic        advance;
  logic [31:0] ir;
  logic [3:0]  icc;
  logic [1:0]  fcc;
  logic        trap_req;
  logic [31:0] trap_vec;

  logic [31:0] pc0, npc0;
  logic        an0, ct0, ba0, bn0;
  logic [15:0] tk0, ac0;

  logic [31:0] pc1, npc1;
  logic        an1, ct1, ba1, bn1;
  logic [15:0] tk1, ac1;

  logic [31:0] pc2, npc2;
  logic        an2, ct2, ba2, bn2;
  logic [1:0]  tk2, ac2;

  int n_cmp;
  int n_bad;

  sparc_branch_sequencer u_dut (
    .Clk(Clk), .RESET(RESET), .advance(advance), .ir(ir),
    .icc(icc), .fcc(fcc), .trap_req(trap_req), .trap_vec(trap_vec),
    .pc(pc0), .npc(npc0), .annul_cur(an0), .cond_true(ct0),
    .is_ba(ba0), .is_bn(bn0), .taken_cnt(tk0), .annul_cnt(ac0)
  );

  sparc_branch_sequencer #(.FCC_EN(0)) u_nf (
    .Clk(Clk), .RESET(RESET), .advance(advance), .ir(ir),
    .icc(icc), .fcc(fcc), .trap_req(trap_req), .trap_vec(trap_vec),
    .pc(pc1), .npc(npc1), .annul_cur(an1), .cond_true(ct1),
    .is_ba(ba1), .is_bn(bn1), .taken_cnt(tk1), .annul_cnt(ac1)
  );

  sparc_branch_sequencer #(.CNT_W(2)) u_c2 (
    .Clk(Clk), .RESET(RESET), .advance(advance), .ir(ir),
    .icc(icc), .fcc(fcc), .trap_req(trap_req), .trap_vec(trap_vec),
    .pc(pc2), .npc(npc2), .annul_cur(an2), .cond_true(ct2),
    .is_ba(ba2), .is_bn(bn2), .taken_cnt(tk2), .annul_cnt(ac2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  localparam logic [31:0] ADD = 32'h8200_4001;

  typedef struct {
    logic        adv;
    logic        trp;
    logic [31:0] ins;
    logic [3:0]  ic;
    logic [1:0]  fc;
    logic [31:0] tv;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic        e_an;
    int          e_tk;
    int          e_ac;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  ic;
    logic [1:0]  fc;
    logic        e_ct;
    logic        e_ba;
    logic        e_bn;
  } cv_t;

  function automatic logic [31:0] br(input logic a, input logic [3:0] c,
                                     input logic [2:0] o2,
                                     input logic [21:0] d);
    return {2'b00, a, c, o2, d};
  endfunction

  function automatic logic [31:0] call(input logic [29:0] d);
    return {2'b01, d};
  endfunction

  function automatic vec_t V(input logic adv, input logic trp,
                             input logic [31:0] ins, input logic [3:0] ic,
                             input logic [1:0] fc, input logic [31:0] tv,
                             input logic [31:0] p, input logic [31:0] np,
                             input logic an, input int tk, input int ac);
    vec_t v;
    v.adv = adv; v.trp = trp; v.ins = ins; v.ic = ic; v.fc = fc;
    v.tv = tv; v.e_pc = p; v.e_npc = np; v.e_an = an;
    v.e_tk = tk; v.e_ac = ac;
    return v;
  endfunction

  function automatic cv_t C(input logic [31:0] ins, input logic [3:0] ic,
                            input logic [1:0] fc, input logic ct,
                            input logic ba, input logic bn);
    cv_t c;
    c.ins = ins; c.ic = ic; c.fc = fc;
    c.e_ct = ct; c.e_ba = ba; c.e_bn = bn;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic adv, input logic trp,
                       input logic [31:0] ins, input logic [3:0] ic,
                       input logic [1:0] fc, input logic [31:0] tv);
    advance = adv; trap_req = trp; ir = ins;
    icc = ic; fcc = fc; trap_vec = tv;
    @(posedge Clk);
    #1;
    advance = 1'b0;
    trap_req = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge Clk);
    #1;
    RESET = 1'b0;
  endtask

  vec_t seq[23];
  cv_t  cv[14];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RESET = 1'b1; advance = 1'b0; trap_req = 1'b0;
    ir = ADD; icc = 4'h0; fcc = 2'd0; trap_vec = 32'h0;

    seq[0]  = V(1, 0, ADD, 4'h0, 0, 0, 32'h4, 32'h8, 0, 0, 0);
    seq[1]  = V(1, 0, ADD, 4'h0, 0, 0, 32'h8, 32'hC, 0, 0, 0);
    seq[2]  = V(1, 0, ADD, 4'h0, 0, 0, 32'hC, 32'h10, 0, 0, 0);
    seq[3]  = V(0, 1, ADD, 4'h0, 0, 32'h100, 32'h100, 32'h104, 0, 0, 0);
    seq[4]  = V(1, 0, br(0, 4'b0001, 3'b010, 22'd4), 4'b0100, 0, 0,
                32'h104, 32'h110, 0, 1, 0);
    seq[5]  = V(1, 0, ADD, 4'h0, 0, 0, 32'h110, 32'h114, 0, 1, 0);
    seq[6]  = V(0, 1, ADD, 4'h0, 0, 32'h100, 32'h100, 32'h104, 0, 1, 0);
    seq[7]  = V(1, 0, br(1, 4'b1001, 3'b010, 22'd4), 4'b0100, 0, 0,
                32'h104, 32'h108, 1, 1, 0);
    seq[8]  = V(1, 0, call(30'h40), 4'h0, 0, 0,
                32'h108, 32'h10C, 0, 1, 1);
    seq[9]  = V(0, 1, ADD, 4'h0, 0, 32'h10, 32'h10, 32'h14, 0, 1, 1);
    seq[10] = V(1, 0, br(1, 4'b1000, 3'b010, 22'h3FFFFE), 4'h0, 0, 0,
                32'h14, 32'h8, 1, 2, 1);
    seq[11] = V(1, 0, ADD, 4'h0, 0, 0, 32'h8, 32'hC, 0, 2, 2);
    seq[12] = V(1, 0, br(1, 4'b0000, 3'b010, 22'd4), 4'h0, 0, 0,
                32'hC, 32'h10, 1, 2, 2);
    seq[13] = V(1, 0, ADD, 4'h0, 0, 0, 32'h10, 32'h14, 0, 2, 3);
    seq[14] = V(1, 0, br(0, 4'b0000, 3'b010, 22'd4), 4'h0, 0, 0,
                32'h14, 32'h18, 0, 2, 3);
    seq[15] = V(1, 0, br(0, 4'b0011, 3'b110, 22'd4), 4'h0, 2'd3, 0,
                32'h18, 32'h24, 0, 3, 3);
    seq[16] = V(1, 0, br(0, 4'b1000, 3'b010, 22'd4), 4'h0, 0, 0,
                32'h24, 32'h28, 0, 4, 3);
    seq[17] = V(1, 0, ADD, 4'h0, 0, 0, 32'h28, 32'h2C, 0, 4, 3);
    seq[18] = V(1, 0, br(1, 4'b0000, 3'b010, 22'd4), 4'h0, 0, 0,
                32'h2C, 32'h30, 1, 4, 3);
    seq[19] = V(1, 1, ADD, 4'h0, 0, 32'h800, 32'h800, 32'h804, 0, 4, 3);
    seq[20] = V(0, 0, call(30'h5), 4'h0, 0, 0,
                32'h800, 32'h804, 0, 4, 3);
    seq[21] = V(0, 1, ADD, 4'h0, 0, 32'hFFFF_FFFC,
                32'hFFFF_FFFC, 32'h0, 0, 4, 3);
    seq[22] = V(1, 0, br(0, 4'b1000, 3'b010, 22'd2), 4'h0, 0, 0,
                32'h0, 32'h4, 0, 5, 3);

    cv[0]  = C(br(0, 4'b0001, 3'b010, 0), 4'b0100, 0, 1, 0, 0);
    cv[1]  = C(br(0, 4'b0001, 3'b010, 0), 4'b0000, 0, 0, 0, 0);
    cv[2]  = C(br(0, 4'b1010, 3'b010, 0), 4'b1000, 0, 0, 0, 0);
    cv[3]  = C(br(0, 4'b1010, 3'b010, 0), 4'b0000, 0, 1, 0, 0);
    cv[4]  = C(br(0, 4'b1100, 3'b010, 0), 4'b0001, 0, 0, 0, 0);
    cv[5]  = C(br(0, 4'b1100, 3'b010, 0), 4'b0000, 0, 1, 0, 0);
    cv[6]  = C(br(0, 4'b0010, 3'b010, 0), 4'b0010, 0, 1, 0, 0);
    cv[7]  = C(br(1, 4'b1000, 3'b010, 0), 4'b0000, 0, 1, 1, 0);
    cv[8]  = C(br(1, 4'b0000, 3'b010, 0), 4'b1111, 0, 0, 0, 1);
    cv[9]  = C(br(0, 4'b0011, 3'b110, 0), 4'b0000, 2'd1, 1, 0, 0);
    cv[10] = C(br(0, 4'b0011, 3'b110, 0), 4'b0000, 2'd2, 0, 0, 0);
    cv[11] = C(br(0, 4'b1111, 3'b110, 0), 4'b0000, 2'd3, 0, 0, 0);
    cv[12] = C(br(0, 4'b1001, 3'b110, 0), 4'b0000, 2'd0, 1, 0, 0);
    cv[13] = C(br(0, 4'b1000, 3'b110, 0), 4'b0000, 2'd2, 1, 1, 0);

    repeat (2) @(posedge Clk);
    #1;
    RESET = 1'b0;

    chk("rst pc", pc0, 32'h0);
    chk("rst npc", npc0, 32'h4);
    chk("rst annul", {31'b0, an0}, 32'h0);
    chk("rst taken", {16'b0, tk0}, 32'h0);
    chk("rst acnt", {16'b0, ac0}, 32'h0);

    for (int i = 0; i < 23; i++) begin
      drive(seq[i].adv, seq[i].trp, seq[i].ins, seq[i].ic,
            seq[i].fc, seq[i].tv);
      chk($sformatf("v%0d pc", i), pc0, seq[i].e_pc);
      chk($sformatf("v%0d npc", i), npc0, seq[i].e_npc);
      chk($sformatf("v%0d annul", i), {31'b0, an0}, {31'b0, seq[i].e_an});
      chk($sformatf("v%0d taken", i), {16'b0, tk0}, seq[i].e_tk);
      chk($sformatf("v%0d acnt", i), {16'b0, ac0}, seq[i].e_ac);
    end

    // FBfcc decode disabled: same FBUL becomes a plain instruction.
    do_reset();
    drive(0, 1, ADD, 4'h0, 0, 32'h14);
    drive(1, 0, br(0, 4'b0011, 3'b110, 22'd4), 4'h0, 2'd3, 0);
    chk("fbul en npc", npc0, 32'h24);
    chk("fbul en taken", {16'b0, tk0}, 32'd1);
    chk("fbul nf pc", pc1, 32'h18);
    chk("fbul nf npc", npc1, 32'h1C);
    chk("fbul nf taken", {16'b0, tk1}, 32'd0);

    // Saturating counter on the CNT_W=2 instance.
    do_reset();
    for (int k = 0; k < 5; k++)
      drive(1, 0, call(30'h1), 4'h0, 0, 0);
    chk("sat c2 taken", {30'b0, tk2}, 32'd3);
    chk("sat wide taken", {16'b0, tk0}, 32'd5);

    // Reset while in a delay slot, with trap and advance also pending.
    do_reset();
    drive(1, 0, br(0, 4'b1000, 3'b010, 22'd8), 4'h0, 0, 0);
    chk("dslot npc", npc0, 32'h20);
    RESET = 1'b1;
    drive(1, 1, call(30'h9), 4'h0, 0, 32'h900);
    RESET = 1'b0;
    chk("rst dslot pc", pc0, 32'h0);
    chk("rst dslot npc", npc0, 32'h4);
    chk("rst dslot taken", {16'b0, tk0}, 32'h0);

    // Reset while annulled clears annul_cur and counters.
    drive(1, 0, br(1, 4'b0000, 3'b010, 22'd8), 4'h0, 0, 0);
    chk("pre rst annul", {31'b0, an0}, 32'h1);
    do_reset();
    chk("rst annul clr", {31'b0, an0}, 32'h0);
    chk("rst annul pc", pc0, 32'h0);

    // Same-cycle condition outputs; advance held low.
    for (int j = 0; j < 14; j++) begin
      ir = cv[j].ins; icc = cv[j].ic; fcc = cv[j].fc;
      #1;
      chk($sformatf("c%0d cond", j), {31'b0, ct0}, {31'b0, cv[j].e_ct});
      chk($sformatf("c%0d ba", j), {31'b0, ba0}, {31'b0, cv[j].e_ba});
      chk($sformatf("c%0d bn", j), {31'b0, bn0}, {31'b0, cv[j].e_bn});
    end
    chk("comb hold pc", pc0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
